// File: rtl/mod_pkg.sv
// Shared types and constants for the byte-to-serial modulator.
// Frame timing defaults assume a 50 MHz system clock.
package mod_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } mod_state_t;

  localparam int MOD_DEFAULT_BIT_CYCLES = 25000;
  localparam int MOD_NBITS = 8;
  localparam int MOD_FRAME_CYCLES =
    MOD_NBITS * MOD_DEFAULT_BIT_CYCLES;
endpackage

// File: rtl/mod_serializer_if.sv
// Byte handshake plus serial line bundle for mod_serializer.
// master = byte source / line observer, slave = the modulator.
interface mod_serializer_if;
  import mod_pkg::*;

  logic [MOD_NBITS-1:0] data;
  logic                 load;
  logic                 ready;
  logic                 busy;
  logic                 NEW_BYTE;
  logic                 signal;

  modport master (
    output data, load,
    input  ready, busy, NEW_BYTE, signal
  );

  modport slave (
    input  data, load,
    output ready, busy, NEW_BYTE, signal
  );
endinterface

// File: rtl/mod_bit_timer.sv
// Bit slot timer: counts 0..BIT_CYCLES-1 while enabled and
// pulses tick on the last count of each slot.
module mod_bit_timer #(
  parameter int BIT_CYCLES = 25000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(BIT_CYCLES);
  localparam logic [W-1:0] LAST = W'(BIT_CYCLES - 1);

  logic [W-1:0] r_cnt;

  assign tick = en & (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst | clr)
      r_cnt <= '0;
    else if (en)
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/mod_serializer.sv
// Byte-to-serial modulator, MSB first, NEW_BYTE marks bit 7.
// Define MOD_REPEAT_EN to retransmit the last byte when idle.
module mod_serializer
  import mod_pkg::*;
#(
  parameter int BIT_CYCLES = MOD_DEFAULT_BIT_CYCLES,
  parameter int NBITS      = MOD_NBITS
) (
  input  logic            clk,
  input  logic            rst,
  mod_serializer_if.slave bus
);
  localparam int IW = $clog2(NBITS);
  localparam logic [IW-1:0] IDX_TOP = IW'(NBITS - 1);

  mod_state_t       r_state;
  logic [NBITS-1:0] r_shreg;
  logic [IW-1:0]    r_idx;
  logic             r_new_byte;
`ifdef MOD_REPEAT_EN
  logic [NBITS-1:0] r_copy;
`endif

  logic w_shift;
  logic w_tick;
  logic w_frame_end;
  logic w_ready;
  logic w_accept;

  assign w_shift     = (r_state == SHIFT);
  assign w_frame_end = w_tick & (r_idx == '0);
  assign w_ready     = ~rst & (~w_shift | w_frame_end);
  assign w_accept    = bus.load & w_ready;

  mod_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_accept),
    .en   (w_shift),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_idx      <= '0;
      r_new_byte <= 1'b0;
`ifdef MOD_REPEAT_EN
      r_copy     <= '0;
`endif
    end else if (w_accept) begin
      r_state    <= SHIFT;
      r_shreg    <= bus.data;
      r_idx      <= IDX_TOP;
      r_new_byte <= 1'b1;
`ifdef MOD_REPEAT_EN
      r_copy     <= bus.data;
`endif
    end else if (w_frame_end) begin
`ifdef MOD_REPEAT_EN
      r_shreg    <= r_copy;
      r_idx      <= IDX_TOP;
      r_new_byte <= 1'b1;
`else
      // last shift leaves shreg zero, so signal idles low
      r_state    <= IDLE;
      r_shreg    <= {r_shreg[NBITS-2:0], 1'b0};
      r_new_byte <= 1'b0;
`endif
    end else if (w_tick) begin
      r_shreg    <= {r_shreg[NBITS-2:0], 1'b0};
      r_idx      <= r_idx - 1'b1;
      r_new_byte <= 1'b0;
    end
  end

  assign bus.ready    = w_ready;
  assign bus.busy     = w_shift;
  assign bus.NEW_BYTE = r_new_byte;
  assign bus.signal   = r_shreg[NBITS-1];
endmodule

// File: tb/tb_mod_serializer.sv
// Scoreboard bench for mod_serializer with a frame-level model.
// Stimulus pushes expected frames; a negedge monitor checks them.
module tb_mod_serializer;
  import mod_pkg::*;

  localparam int B = 4;
  localparam int FRAME =
    (MOD_FRAME_CYCLES / MOD_DEFAULT_BIT_CYCLES) * B;

  typedef struct {
    logic [7:0] b;
    int         start;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mod_serializer_if sif();

  mod_serializer #(
    .BIT_CYCLES(B),
    .NBITS(MOD_NBITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  frame_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  bit chk_en = 0;
  bit exp_ready = 0;
  bit exp_busy = 0;
  bit active = 0;
  int m_last = 0;
  logic [7:0] last_b = 0;
  bit have_last = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s at cycle %0d: got %0h, want %0h",
                 nm, cyc, act, want);
    end
  endtask

  task automatic start_frame(input logic [7:0] d, input int c);
    active    = 1;
    m_last    = c + FRAME;
    last_b    = d;
    have_last = 1;
    q.push_back('{b: d, start: c + 1});
  endtask

  // One cycle of stimulus; the model decides acceptance itself.
  task automatic drive(input bit r, input bit l,
                       input logic [7:0] d);
    int c;
    c = cyc;
    rst = r;
    sif.load = l;
    sif.data = d;
    if (active && c > m_last) active = 0;
    exp_busy  = active;
    exp_ready = !r && (!active || c == m_last);
    chk_en = 1;
    if (r) begin
      active    = 0;
      have_last = 0;
    end else if (l && exp_ready) begin
      start_frame(d, c);
    end
`ifdef MOD_REPEAT_EN
    else if (active && c == m_last && have_last) begin
      start_frame(last_b, c);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  frame_t     cur;
  bit         in_frame = 0;
  int         off = 0;
  int         errs = 0;
  logic [7:0] got = 0;
  logic       exp_bit;
  logic       exp_nb;

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {31'b0, sif.ready}, {31'b0, exp_ready});
      check("busy", {31'b0, sif.busy}, {31'b0, exp_busy});
      if (!in_frame && sif.NEW_BYTE === 1'b1) begin
        check("frame_queue", q.size(), 1);
        if (q.size() > 0) begin
          cur = q.pop_front();
          check("frame_start", cyc, cur.start);
          in_frame = 1;
          off = 0;
          errs = 0;
          got = 0;
        end
      end
      if (in_frame) begin
        exp_bit = cur.b[7 - off / B];
        exp_nb = (off < B);
        if (sif.signal !== exp_bit || sif.NEW_BYTE !== exp_nb)
          errs++;
        if (off % B == B / 2)
          got = {got[6:0], sif.signal};
        off++;
        if (off == 8 * B) begin
          check("frame_byte", {24'b0, got}, {24'b0, cur.b});
          check("frame_bits", errs, 0);
          in_frame = 0;
        end
      end else begin
        check("idle_out", {30'b0, sif.signal, sif.NEW_BYTE}, 0);
      end
      if (rst) in_frame = 0;
    end
  end

  initial begin
    int k;
    sif.load = 1'b0;
    sif.data = 8'h00;
    rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) drive(1'b1, 1'b0, 8'h00);

    drive(1'b0, 1'b1, 8'hA5);
    idle(40);

    drive(1'b0, 1'b1, 8'hFF);
    repeat (32) drive(1'b0, 1'b1, 8'h00);
    idle(40);

    drive(1'b0, 1'b1, 8'h96);
    idle(9);
    drive(1'b0, 1'b1, 8'h3C);
    idle(40);

    drive(1'b0, 1'b1, 8'hF0);
    idle(12);
    drive(1'b1, 1'b0, 8'h00);
    idle(2);
    drive(1'b0, 1'b1, 8'h81);
    idle(40);

`ifdef MOD_REPEAT_EN
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h5A);
    idle(70);
    k = 0;
    while (!(active && cyc == m_last) && k < 100) begin
      drive(1'b0, 1'b0, 8'h00);
      k++;
    end
    drive(1'b0, 1'b1, 8'h01);
    idle(70);
`endif

    repeat (2500)
      drive($urandom_range(0, 399) == 0,
            $urandom_range(0, 5) == 0,
            8'($urandom));

    idle(40);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    idle(5);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
